// File: rtl/fifo_sync_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_pkg
//   Shared types for the fifo_sync block. The per-cycle operation is the pair
//   (read accepted, write accepted). It is carried as an enum so the occupancy
//   update in the top level reads as a decision on named cases.
// -----------------------------------------------------------------------------
package fifo_sync_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Combine the two accept strobes into one operation code.
  function automatic fifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
    return fifo_op_e'({rd_ok, wr_ok});
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// -----------------------------------------------------------------------------
// fifo_sync_mem
//   DEPTH x WIDTH register array with one synchronous write port and one
//   registered read port. The read register holds its value when re is low.
//   Only the read register is reset, so RD is defined from the first reset.
//
// Ports
//   clk    in   1       rising-edge clock
//   rst    in   1       synchronous active-high reset (read register only)
//   we     in   1       write enable
//   waddr  in   ADDR_W  write address
//   wdata  in   WIDTH   write data
//   re     in   1       read enable; rdata loads mem[raddr] on this edge
//   raddr  in   ADDR_W  read address
//   rdata  out  WIDTH   registered read data
// -----------------------------------------------------------------------------
module fifo_sync_mem #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset. Its contents before the first write
  // are never observable, because a read is only accepted when count > 0.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A write and a read may hit the same slot in one cycle (full FIFO, both
  // strobes). The read samples the old word and the write lands afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
//   Single-clock FIFO with a registered read data output and registered
//   FULL/EMPTY flags. The depth need not be a power of two: the pointers wrap
//   explicitly at MEMORY_DEPTH-1.
//
// Ports
//   clk    in   1             rising-edge clock
//   rst    in   1             synchronous active-high reset
//   w_en   in   1             write request
//   r_en   in   1             read request
//   WR     in   MEMORY_WIDTH  write data
//   FULL   out  1             MEMORY_DEPTH entries stored
//   EMPTY  out  1             no entries stored
//   RD     out  MEMORY_WIDTH  read data register (1-cycle latency, holds)
// -----------------------------------------------------------------------------
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int MEMORY_WIDTH = 4,
  parameter int MEMORY_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic [MEMORY_WIDTH-1:0] WR,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [MEMORY_WIDTH-1:0] RD
);

  localparam int PTR_W = $clog2(MEMORY_DEPTH);
  localparam int CNT_W = $clog2(MEMORY_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MEMORY_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEMORY_DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_next;
  logic [PTR_W-1:0] rptr_q, rptr_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic             full_q, empty_q;
  logic             wr_ok, rd_ok;
  fifo_op_e         op;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Accept logic uses only registered flags, so neither flag has a
  // combinational path from w_en/r_en. A write into a full FIFO is accepted
  // when a read frees a slot in the same cycle. A read of an empty FIFO is
  // ignored even if a write arrives, so there is no fall-through.
  // NOTE: every always_comb output gets a default first. A path that leaves a
  // signal unassigned would infer a latch.
  always_comb begin
    wr_ok      = w_en & (~full_q | r_en);
    rd_ok      = r_en & ~empty_q;
    op         = decode_op(wr_ok, rd_ok);
    wptr_next  = wr_ok ? inc_ptr(wptr_q) : wptr_q;
    rptr_next  = rd_ok ? inc_ptr(rptr_q) : rptr_q;
    count_next = count_q;
    case (op)
      OP_WRITE: count_next = count_q + 1'b1;
      OP_READ:  count_next = count_q - 1'b1;
      default:  count_next = count_q;  // idle or balanced read+write
    endcase
  end

  // The flags are registered from count_next. They change on the same edge as
  // count, without a decode stage after the register.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from pre-edge values, and there is no ordering race
  // between always blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_next;
      rptr_q  <= rptr_next;
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_CNT);
      empty_q <= (count_next == '0);
    end
  end

  fifo_sync_mem #(
    .WIDTH  (MEMORY_WIDTH),
    .DEPTH  (MEMORY_DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (WR),
    .re    (rd_ok),
    .raddr (rptr_q),
    .rdata (RD)
  );

  assign FULL  = full_q;
  assign EMPTY = empty_q;

endmodule

// File: tb/tb_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync
//   Directed test of fifo_sync (depth 4, width 4). A queue-based reference
//   model tracks the expected FULL/EMPTY/RD. A compare process checks the DUT
//   against the model on every falling edge after the first reset. Literal
//   expectations at key points pin both the model and the DUT.
// -----------------------------------------------------------------------------
module tb_fifo_sync;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         w_en = 1'b0;
  logic         r_en = 1'b0;
  logic [W-1:0] WR = '0;
  logic         FULL, EMPTY;
  logic [W-1:0] RD;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_rd = '0;
  bit           m_valid = 1'b0;

  fifo_sync #(.MEMORY_WIDTH(W), .MEMORY_DEPTH(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .w_en  (w_en),
    .r_en  (r_en),
    .WR    (WR),
    .FULL  (FULL),
    .EMPTY (EMPTY),
    .RD    (RD)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, advance the model at the
  // rising edge using the same inputs, then settle 1 time unit.
  task automatic cycle(input bit r_st, input bit w, input bit r, input logic [W-1:0] d);
    bit rd_ok, wr_ok;
    @(negedge clk);
    rst = r_st; w_en = w; r_en = r; WR = d;
    @(posedge clk);
    if (r_st) begin
      m_q.delete();
      m_rd = '0;
      m_valid = 1'b1;
    end else begin
      rd_ok = r && (m_q.size() > 0);
      wr_ok = w && ((m_q.size() < D) || r);
      if (rd_ok) m_rd = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic wr(input logic [W-1:0] d); cycle(0, 1, 0, d); endtask
  task automatic rd();                      cycle(0, 0, 1, '0); endtask
  task automatic idle();                    cycle(0, 0, 0, '0); endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_full",  FULL,  (m_q.size() == D));
      check("cyc_empty", EMPTY, (m_q.size() == 0));
      check("cyc_rd",    RD,    m_rd);
    end
  end

  initial begin
    // Reset held for two edges, then idle.
    cycle(1, 1, 1, 4'hF);
    cycle(1, 0, 0, '0);
    check("rst_empty", EMPTY, 1);
    check("rst_full",  FULL,  0);
    check("rst_rd",    RD,    0);
    repeat (3) idle();
    check("idle_empty", EMPTY, 1);
    check("idle_rd",    RD,    0);

    // Two writes, three reads. The third read is ignored.
    wr(4'd1); wr(4'd2);
    check("wr2_empty", EMPTY, 0);
    rd(); check("r1_rd", RD, 1); check("r1_model", m_rd, 1);
    rd(); check("r2_rd", RD, 2); check("r2_empty", EMPTY, 1);
    rd(); check("r3_rd_hold", RD, 2);

    // Fill, dropped write, drain.
    wr(4'd3); wr(4'd4); wr(4'd5);
    check("fill3_full", FULL, 0);
    wr(4'd6);
    check("fill4_full", FULL, 1); check("fill4_model", m_q.size(), 4);
    wr(4'd7);
    check("drop_full", FULL, 1);
    for (int i = 0; i < 4; i++) begin
      rd(); check("drain_rd", RD, 3 + i);
    end
    check("drain_empty", EMPTY, 1); check("drain_full", FULL, 0);

    // Pointer wrap: 5 x (two writes, three reads), data 1..10.
    for (int k = 0; k < 5; k++) begin
      wr(W'(2*k + 1)); wr(W'(2*k + 2));
      rd(); check("wrap_rd_a", RD, 2*k + 1);
      rd(); check("wrap_rd_b", RD, 2*k + 2);
      rd(); check("wrap_rd_hold", RD, 2*k + 2);
      check("wrap_empty", EMPTY, 1);
    end

    // Simultaneous read+write while full.
    wr(4'd11); wr(4'd12); wr(4'd13); wr(4'd14);
    cycle(0, 1, 1, 4'd9);
    check("both_full_rd", RD, 11); check("both_full_flag", FULL, 1);
    rd(); check("bf_rd1", RD, 12);
    rd(); check("bf_rd2", RD, 13);
    rd(); check("bf_rd3", RD, 14);
    rd(); check("bf_rd4_last", RD, 9); check("bf_empty", EMPTY, 1);

    // Simultaneous read+write while empty: no fall-through.
    wr(4'd6); rd(); check("pre_rd", RD, 6);
    cycle(0, 1, 1, 4'd9);
    check("both_empty_rd", RD, 6); check("both_empty_flag", EMPTY, 0);
    rd(); check("both_empty_next", RD, 9); check("be_empty", EMPTY, 1);

    // Reset mid-operation.
    wr(4'd1); wr(4'd2); wr(4'd3);
    cycle(1, 0, 0, '0);
    check("mid_rst_empty", EMPTY, 1); check("mid_rst_rd", RD, 0); check("mid_rst_full", FULL, 0);
    rd();
    check("post_rst_rd", RD, 0); check("post_rst_empty", EMPTY, 1);

    idle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
